// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hcu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signal bundle for the hazard control unit.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [4:0]           ID_Rs1;
    logic [4:0]           ID_Rs2;
    logic                 ID_UsesRs1;
    logic                 ID_UsesRs2;
    logic                 EX_MemRead;
    logic [4:0]           EX_Rd;
    logic                 EX_Redirect;
    logic                 MEM_MemRead;
    logic                 MEM_MemWrite;
    logic                 dmem_ready;
    logic                 imem_valid;

    logic                 dmem_req;
    logic                 pc_stall;
    logic                 IF_ID_stall;
    logic                 IF_ID_flush;
    logic                 ID_EX_stall;
    logic                 ID_EX_flush;
    logic                 EX_MEM_stall;
    logic                 EX_MEM_flush;
    logic                 MEM_WB_flush;
    logic                 mem_error;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] redirect_count;

    // Pipeline/core side: supplies hazard inputs, consumes controls.
    modport master (
        output ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Rd, EX_Redirect,
               MEM_MemRead, MEM_MemWrite, dmem_ready, imem_valid,
        input  dmem_req, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, mem_error, stall_cycles,
               redirect_count
    );

    modport slave (
        input  ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Rd, EX_Redirect,
               MEM_MemRead, MEM_MemWrite, dmem_ready, imem_valid,
        output dmem_req, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, mem_error, stall_cycles,
               redirect_count
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush sequencer: load-use, redirect, fetch miss and data-memory wait/timeout.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_WIDTH    = 8
) (
    input logic           clk,
    input logic           reset,
    hazard_control_unit_if.slave hcu
);

    hcu_state_e          state_q, state_d;
    logic [TO_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                mem_error_q, mem_error_d;

    logic memop;
    logic mem_wait;
    logic load_use;
    logic redirect_taken;
    logic stall_any;

    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] redir_cnt;

    assign memop    = hcu.MEM_MemRead | hcu.MEM_MemWrite;
    assign mem_wait = memop & ~hcu.dmem_ready & (state_q != ERROR);

    assign load_use = hcu.EX_MemRead & (hcu.EX_Rd != REG_ZERO) &
                      ((hcu.ID_UsesRs1 & (hcu.EX_Rd == hcu.ID_Rs1)) |
                       (hcu.ID_UsesRs2 & (hcu.EX_Rd == hcu.ID_Rs2)));

    // Outputs are forced low while reset is held, independent of state.
    always_comb begin
        hcu.dmem_req     = 1'b0;
        hcu.pc_stall     = 1'b0;
        hcu.IF_ID_stall  = 1'b0;
        hcu.IF_ID_flush  = 1'b0;
        hcu.ID_EX_stall  = 1'b0;
        hcu.ID_EX_flush  = 1'b0;
        hcu.EX_MEM_stall = 1'b0;
        hcu.EX_MEM_flush = 1'b0;
        hcu.MEM_WB_flush = 1'b0;
        redirect_taken   = 1'b0;
        if (!reset) begin
            hcu.dmem_req = memop & (state_q != ERROR);
            if ((state_q == ERROR) || mem_wait) begin
                hcu.pc_stall     = 1'b1;
                hcu.IF_ID_stall  = 1'b1;
                hcu.ID_EX_stall  = 1'b1;
                hcu.EX_MEM_stall = 1'b1;
                hcu.MEM_WB_flush = 1'b1;
            end else if (hcu.EX_Redirect) begin
                // ID holds a wrong-path instruction, so lower hazards are moot.
                hcu.IF_ID_flush = 1'b1;
                hcu.ID_EX_flush = 1'b1;
                redirect_taken  = 1'b1;
            end else if (load_use) begin
                hcu.pc_stall    = 1'b1;
                hcu.IF_ID_stall = 1'b1;
                hcu.ID_EX_flush = 1'b1;
            end else if (!hcu.imem_valid) begin
                hcu.pc_stall    = 1'b1;
                hcu.IF_ID_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_WIDTH'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt_q == TO_WIDTH'(MEM_TIMEOUT)) begin
                        state_d     = ERROR;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_WIDTH'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERROR: begin
                mem_error_d = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign stall_any = hcu.pc_stall | hcu.IF_ID_stall;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_any),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_redir_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_taken),
        .count (redir_cnt)
    );

    assign hcu.stall_cycles   = stall_cnt;
    assign hcu.redirect_count = redir_cnt;
    assign hcu.mem_error      = mem_error_q;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central sequencing controller for the 5-stage pipeline. Generates per-stage stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Detects load-use hazards and resolves EX-stage redirects (taken branch/jump).
- Owns the data-memory request/ready handshake, including timeout detection.
- Keeps saturating performance counters. Sits beside the pipeline registers in the core top level.

Parameters:
- CNT_WIDTH, 32, width of the performance counters.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before the error state; must be ≥1.
- TO_WIDTH, 8, width of the wait counter; must satisfy 2^TO_WIDTH > MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ID_Rs1, ID_Rs2  in  5 each  source registers of the instruction in ID
- ID_UsesRs1, ID_UsesRs2  in  1 each  ID instruction actually reads rs1/rs2
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rd  in  5  destination register of the EX instruction
- EX_Redirect  in  1  branch taken or jump resolved in EX; PC mux selects target
- MEM_MemRead, MEM_MemWrite  in  1 each  memory operation in MEM
- dmem_ready  in  1  data memory completes the current access this cycle
- imem_valid  in  1  instruction fetch data valid this cycle
- dmem_req  out  1  data memory request
- pc_stall  out  1  hold PC
- IF_ID_stall, IF_ID_flush  out  1 each  IF/ID control
- ID_EX_stall, ID_EX_flush  out  1 each  ID/EX control
- EX_MEM_stall, EX_MEM_flush  out  1 each  EX/MEM control
- MEM_WB_flush  out  1  insert bubble into MEM/WB
- mem_error  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_WIDTH  cycles with any stall asserted
- redirect_count  out  CNT_WIDTH  number of redirects taken

Behaviour:
- State machine: RUN, MEM_WAIT, ERROR. Reset: RUN, wait counter 0, counters 0, mem_error 0. All stall/flush outputs and dmem_req read 0 during reset.
- Stall/flush outputs are combinational (Mealy) from state and inputs. Counters, state and mem_error are registered.
- memop = MEM_MemRead | MEM_MemWrite. dmem_req = memop in RUN and MEM_WAIT, 0 in ERROR.
- Priority, highest first: ERROR > memory wait > redirect > load-use > fetch miss > none.
- Memory wait (memop & !dmem_ready, in RUN or MEM_WAIT):
  - pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall = 1; MEM_WB_flush = 1; all other flushes 0.
  - RUN→MEM_WAIT with wait counter 1. In MEM_WAIT, counter increments each cycle.
  - On the cycle the counter equals MEM_TIMEOUT with ready still low, next state is ERROR.
- Zero-wait access (memop & dmem_ready in RUN): no stall.
- MEM_WAIT with dmem_ready=1: stalls released that cycle, MEM_WB captures normally, next state RUN, counter cleared. Lower-priority hazards are evaluated in this same cycle.
- Redirect (EX_Redirect, no memory wait): IF_ID_flush = 1, ID_EX_flush = 1, pc_stall = 0 so the target loads. Load-use and fetch miss are suppressed because the ID instruction is wrong-path. redirect_count increments.
- A redirect during a memory wait is held by the frozen EX stage and takes effect on the release cycle.
- Load-use: EX_MemRead & EX_Rd≠0 & ((ID_UsesRs1 & EX_Rd==ID_Rs1) | (ID_UsesRs2 & EX_Rd==ID_Rs2)).
  - pc_stall = 1, IF_ID_stall = 1, ID_EX_flush = 1. Exactly one bubble.
- Fetch miss (!imem_valid, nothing higher active): pc_stall = 1, IF_ID_flush = 1. With load-use also active, load-use outputs win and IF_ID holds.
- ERROR: every stall = 1, MEM_WB_flush = 1, dmem_req = 0, mem_error = 1. Exit only via reset.
- stall_cycles increments when pc_stall | IF_ID_stall; it saturates at all-ones, and redirect_count also saturates.
- Reset mid-MEM_WAIT: immediate return to RUN, counters cleared, outputs 0.

Decomposition:
- Shared core package (hazard_pkg): hcu_state_e enum (RUN, MEM_WAIT, ERROR) and the constant REG_ZERO = 5'd0.
- One sub-module, sat_counter (parameter WIDTH; ports clk, reset, inc, count), instantiated twice.
- The wait counter stays inline.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs1=5, ID_UsesRs1=1 → one cycle of pc_stall=IF_ID_stall=ID_EX_flush=1, stall_cycles=1. Repeat with EX_Rd=0 → no stall.
- Redirect vs load-use: EX_Redirect=1 with a load-use match → IF_ID_flush=ID_EX_flush=1, pc_stall=0, redirect_count=1.
- Memory wait: MEM_MemRead=1, dmem_ready low 3 cycles then high → dmem_req=1 for 4 cycles; stalls + MEM_WB_flush for 3 cycles, released on the 4th; state back to RUN; stall_cycles=3.
- Timeout with MEM_TIMEOUT=4: MEM_MemWrite=1, ready never high → ERROR after the 4th wait cycle, mem_error=1, dmem_req=0, all stalls high. Later ready=1 has no effect; reset clears everything.
- Fetch miss combined with load-use: imem_valid=0 alone → pc_stall=IF_ID_flush=1. Add a load-use match → IF_ID_stall=1, IF_ID_flush=0.
- Reset mid-wait plus saturation: assert reset during MEM_WAIT → outputs 0 asynchronously, state RUN. With CNT_WIDTH=2, 5 stall cycles → stall_cycles=3.
